// File: rtl/dualport_mem_if.sv
// dualport_mem_if: request/response bundle for the two ports of dualport_mem
// master: drives en/we/be/addr/din per port; slave: drives dout/vld per port, coll and busy
interface dualport_mem_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 14
);
  logic              en_a, we_a, en_b, we_b;
  logic [DATA_W/8-1:0] be_a, be_b;
  logic [ADDR_W-1:0] addr_a, addr_b;
  logic [DATA_W-1:0] din_a, din_b, dout_a, dout_b;
  logic              vld_a, vld_b, coll, busy;
  modport master (
    output en_a, we_a, be_a, addr_a, din_a, en_b, we_b, be_b, addr_b, din_b,
    input  dout_a, vld_a, dout_b, vld_b, coll, busy
  );
  modport slave (
    input  en_a, we_a, be_a, addr_a, din_a, en_b, we_b, be_b, addr_b, din_b,
    output dout_a, vld_a, dout_b, vld_b, coll, busy
  );
endinterface

// File: rtl/dualport_mem.sv
// dualport_mem: true dual-port byte-enabled RAM, zero-cleared after reset, read-first
// ports: clk, rstn (sync active-low), bus (dualport_mem_if.slave: per-port en/we/be/addr/din
//        in, dout/vld out; coll write/write same-address pulse; busy high during clear)
// DUALPORT_MEM_OUTREG_EN: adds a second output stage (dout/vld/coll latency 2)
module dualport_mem #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 14
) (
  input logic clk,
  input logic rstn,
  dualport_mem_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_W;
  localparam int NB = DATA_W / 8;
  typedef enum logic {CLEAR, READY} state_t;
  state_t state, state_nx;
  logic [ADDR_W-1:0] ptr;
  logic [DATA_W-1:0] mem [DEPTH];
  logic ready, rd_a, rd_b, wr_a, wr_b;
  logic [DATA_W-1:0] dout1_a, dout1_b;
  logic vld1_a, vld1_b, coll1;
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= CLEAR;
      ptr <= '0;
    end else begin
      state <= state_nx;
      ptr <= (state == CLEAR) ? ptr + 1'b1 : '0;
    end
  end
  always_comb begin
    state_nx = state;
    if (state == CLEAR && &ptr) state_nx = READY;
  end
  assign ready = rstn && state == READY;
  assign rd_a = ready && bus.en_a && !bus.we_a;
  assign rd_b = ready && bus.en_b && !bus.we_b;
  assign wr_a = ready && bus.en_a && bus.we_a;
  assign wr_b = ready && bus.en_b && bus.we_b;
  // B is written before A so that A wins on lanes both ports enable
  always_ff @(posedge clk) begin
    if (rstn && state == CLEAR) mem[ptr] <= '0;
    for (int i = 0; i < NB; i++) begin
      if (wr_b && bus.be_b[i]) mem[bus.addr_b][i*8 +: 8] <= bus.din_b[i*8 +: 8];
      if (wr_a && bus.be_a[i]) mem[bus.addr_a][i*8 +: 8] <= bus.din_a[i*8 +: 8];
    end
  end
  always_ff @(posedge clk) begin
    if (!rstn) begin
      dout1_a <= '0;
      dout1_b <= '0;
      vld1_a <= 1'b0;
      vld1_b <= 1'b0;
      coll1 <= 1'b0;
    end else begin
      vld1_a <= rd_a;
      vld1_b <= rd_b;
      coll1 <= wr_a && wr_b && bus.addr_a == bus.addr_b;
      if (rd_a) dout1_a <= mem[bus.addr_a];
      if (rd_b) dout1_b <= mem[bus.addr_b];
    end
  end
`ifdef DUALPORT_MEM_OUTREG_EN
  logic [DATA_W-1:0] dout2_a, dout2_b;
  logic vld2_a, vld2_b, coll2;
  always_ff @(posedge clk) begin
    if (!rstn) begin
      dout2_a <= '0;
      dout2_b <= '0;
      vld2_a <= 1'b0;
      vld2_b <= 1'b0;
      coll2 <= 1'b0;
    end else begin
      vld2_a <= vld1_a;
      vld2_b <= vld1_b;
      coll2 <= coll1;
      if (vld1_a) dout2_a <= dout1_a;
      if (vld1_b) dout2_b <= dout1_b;
    end
  end
  assign bus.dout_a = dout2_a;
  assign bus.dout_b = dout2_b;
  assign bus.vld_a = vld2_a;
  assign bus.vld_b = vld2_b;
  assign bus.coll = coll2;
`else
  assign bus.dout_a = dout1_a;
  assign bus.dout_b = dout1_b;
  assign bus.vld_a = vld1_a;
  assign bus.vld_b = vld1_b;
  assign bus.coll = coll1;
`endif
  assign bus.busy = state == CLEAR;
endmodule

// File: tb/tb_dualport_mem.sv
// tb_dualport_mem: directed self-checking bench for dualport_mem (DATA_W=32, ADDR_W=4)
module tb_dualport_mem;
`ifdef DUALPORT_MEM_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif
  logic clk = 1'b0;
  logic rstn = 1'b0;
  int checks = 0;
  int failures = 0;
  int cnt;
  logic seen;
  dualport_mem_if #(.DATA_W(32), .ADDR_W(4)) bus ();
  dualport_mem #(.DATA_W(32), .ADDR_W(4)) dut (.clk(clk), .rstn(rstn), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic set_a(input logic we, input logic [3:0] be, input logic [3:0] addr, input logic [31:0] din);
    bus.en_a = 1'b1; bus.we_a = we; bus.be_a = be; bus.addr_a = addr; bus.din_a = din;
  endtask
  task automatic set_b(input logic we, input logic [3:0] be, input logic [3:0] addr, input logic [31:0] din);
    bus.en_b = 1'b1; bus.we_b = we; bus.be_b = be; bus.addr_b = addr; bus.din_b = din;
  endtask
  // one request cycle, then wait until its results are visible
  task automatic cyc();
    @(negedge clk);
    bus.en_a = 1'b0;
    bus.en_b = 1'b0;
    repeat (LAT - 1) @(negedge clk);
  endtask
  task automatic wait_clear(input string tag);
    cnt = 0;
    seen = 1'b0;
    while (bus.busy && cnt < 40) begin
      cnt++;
      @(negedge clk);
      seen = seen | bus.vld_a | bus.vld_b | bus.coll;
    end
    bus.en_a = 1'b0;
    bus.en_b = 1'b0;
    chk(tag, 32'(cnt), 32'd16);
  endtask
  initial begin
    {bus.en_a, bus.we_a, bus.be_a, bus.addr_a, bus.din_a} = '0;
    {bus.en_b, bus.we_b, bus.be_b, bus.addr_b, bus.din_b} = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 32'd1);
    chk("rst_vld_a", 32'(bus.vld_a), 32'd0);
    chk("rst_dout_b", bus.dout_b, 32'd0);
    chk("rst_coll", 32'(bus.coll), 32'd0);
    rstn = 1'b1;
    wait_clear("clear_cycles");
    for (int i = 0; i < 16 + LAT; i++) begin
      if (i < 16) set_a(1'b0, 4'h0, 4'(i), 32'h0); else bus.en_a = 1'b0;
      @(negedge clk);
      if (i + 1 >= LAT && i + 1 - LAT < 16) begin
        chk($sformatf("clr_vld%0d", i + 1 - LAT), 32'(bus.vld_a), 32'd1);
        chk($sformatf("clr_dat%0d", i + 1 - LAT), bus.dout_a, 32'h0);
      end
    end
    chk("vld_drop", 32'(bus.vld_a), 32'd0);
    set_a(1'b1, 4'hF, 4'd3, 32'hAABBCCDD); cyc();
    chk("wr_no_vld", 32'(bus.vld_a), 32'd0);
    set_a(1'b1, 4'h5, 4'd3, 32'h11223344); cyc();
    set_b(1'b0, 4'h0, 4'd3, 32'h0); cyc();
    chk("be_merge_vld", 32'(bus.vld_b), 32'd1);
    chk("be_merge", bus.dout_b, 32'hAA22CC44);
    chk("wr_keep_dout", bus.dout_a, 32'h0);
    set_a(1'b1, 4'h0, 4'd3, 32'hFFFFFFFF); cyc();
    set_a(1'b0, 4'hF, 4'd3, 32'h0); cyc();
    chk("be_zero_noop", bus.dout_a, 32'hAA22CC44);
    set_a(1'b1, 4'h3, 4'd5, 32'h11111111);
    set_b(1'b1, 4'hE, 4'd5, 32'h22222222); cyc();
    chk("coll_pulse", 32'(bus.coll), 32'd1);
    @(negedge clk);
    chk("coll_one_cycle", 32'(bus.coll), 32'd0);
    set_a(1'b0, 4'h0, 4'd5, 32'h0); cyc();
    chk("coll_merge", bus.dout_a, 32'h22221111);
    set_a(1'b1, 4'hF, 4'd8, 32'h1);
    set_b(1'b1, 4'hF, 4'd9, 32'h2); cyc();
    chk("no_coll_diff", 32'(bus.coll), 32'd0);
    set_a(1'b0, 4'h0, 4'd8, 32'h0);
    set_b(1'b0, 4'h0, 4'd8, 32'h0); cyc();
    chk("no_coll_rd", 32'(bus.coll), 32'd0);
    chk("rd_both_a", bus.dout_a, 32'h1);
    chk("rd_both_b", bus.dout_b, 32'h1);
    set_a(1'b1, 4'hF, 4'd7, 32'hDEADBEEF);
    set_b(1'b0, 4'h0, 4'd7, 32'h0); cyc();
    chk("rdw_old", bus.dout_b, 32'h0);
    chk("rdw_no_coll", 32'(bus.coll), 32'd0);
    set_b(1'b0, 4'h0, 4'd7, 32'h0); cyc();
    chk("rdw_new", bus.dout_b, 32'hDEADBEEF);
    rstn = 1'b0;
    @(negedge clk);
    chk("rst_mid_dout", bus.dout_b, 32'h0);
    chk("rst_mid_busy", 32'(bus.busy), 32'd1);
    rstn = 1'b1;
    repeat (9) @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    set_a(1'b1, 4'hF, 4'd3, 32'h12345678);
    set_b(1'b0, 4'h0, 4'd5, 32'h0);
    wait_clear("restart_cycles");
    chk("busy_ignore", 32'(seen), 32'd0);
    set_a(1'b0, 4'h0, 4'd3, 32'h0);
    set_b(1'b0, 4'h0, 4'd7, 32'h0); cyc();
    chk("reclear_a3", bus.dout_a, 32'h0);
    chk("reclear_b7", bus.dout_b, 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/dualport_mem.md
DUALPORT_MEM -- requirements
Module: dualport_mem

Interface
REQ-001 SHALL have parameter DATA_W, default 32, word width in bits; legal values are multiples of 8.
REQ-002 SHALL have parameter ADDR_W, default 14, word address width; DEPTH = 2**ADDR_W words.
REQ-003 SHALL have a single clock and a synchronous, active-low reset: clk  in  1  clock, all logic on rising edge; rstn  in  1  synchronous active-low reset.
REQ-004 SHALL have port busy  out  1  high while the post-reset clear sequence runs.
REQ-005 SHALL have, per port p in {a,b}: en_p  in  1  access request; we_p  in  1  write when high, read when low.
REQ-006 SHALL have, per port p: be_p  in  DATA_W/8  byte-lane write enables; addr_p  in  ADDR_W  word address; din_p  in  DATA_W  write data.
REQ-007 SHALL have, per port p: dout_p  out  DATA_W  read data; vld_p  out  1  one-cycle pulse marking new dout_p.
REQ-008 SHALL have port coll  out  1  one-cycle pulse on a same-address write/write collision.

Function
REQ-009 SHALL implement a clear FSM with states CLEAR and READY.
REQ-010 In CLEAR, SHALL write zero to word ptr each cycle, ptr counting 0..DEPTH-1, and move to READY after writing DEPTH-1.
REQ-011 SHALL drive busy high in CLEAR and low in READY; the clear takes exactly DEPTH cycles after rstn deasserts.
REQ-012 While busy, SHALL ignore all port requests: no write, no vld, no coll.
REQ-013 On a write (en=1, we=1), SHALL update only the byte lanes with be[i]=1 and preserve all other lanes.
REQ-014 A write with be all-zero SHALL be a no-op.
REQ-015 On a read (en=1, we=0), SHALL return the full word regardless of be.
REQ-016 Read latency SHALL be 1 cycle: request at edge N, dout and vld valid after edge N+1.
REQ-017 dout SHALL hold its last read value until the next read; vld SHALL be high only in the cycle new data appears.
REQ-018 Writes SHALL produce no vld and SHALL leave dout unchanged.
REQ-019 Read-during-write to the same address, on the same port or across ports, SHALL return the old word (read-first).
REQ-020 When both ports write the same address in one cycle, lanes enabled by A SHALL take din_a; lanes enabled only by B SHALL take din_b.
REQ-021 In that collision case, coll SHALL pulse high one cycle later.
REQ-022 Writes to different addresses, or any read combination, SHALL never assert coll.

Reset
REQ-023 While rstn=0 at a rising edge: state <= CLEAR, ptr <= 0, busy <= 1, dout_a/b <= 0, vld_a/b <= 0, coll <= 0.
REQ-024 Reset asserted mid-clear or mid-operation SHALL restart the clear from address 0; in-flight reads SHALL be discarded.
REQ-025 Memory contents SHALL be undefined only while rstn is low and before the clear completes.

Configuration
REQ-026 Macro DUALPORT_MEM_OUTREG_EN defined: a second output register stage SHALL be added; read latency becomes 2 cycles for dout, vld and coll.
REQ-027 Both register stages SHALL reset to 0 and flush on reset.
REQ-028 DUALPORT_MEM_OUTREG_EN undefined: read latency SHALL be 1 cycle as in REQ-016, with no extra stage present.

Verification (DATA_W=32, ADDR_W=4, macro undefined unless stated)
REQ-029 Release rstn -> busy high exactly 16 cycles then low; a read of each of addresses 0..15 returns 0x00000000 with vld pulsing 1 cycle after each request.
REQ-030 Write A addr 3 = 0xAABBCCDD be=0xF, then A addr 3 = 0x11223344 be=0x5, then read B addr 3 -> dout_b = 0xAA22CC44 one cycle after the read request.
REQ-031 Same cycle: A writes addr 5 = 0x11111111 be=0x3, B writes addr 5 = 0x22222222 be=0xE -> coll pulses 1 cycle; subsequent read of addr 5 = 0x22221111.
REQ-032 Addr 7 holds 0x0; same cycle: A writes addr 7 = 0xDEADBEEF, B reads addr 7 -> dout_b = 0x0; a read the next cycle -> 0xDEADBEEF.
REQ-033 Assert rstn low for 1 cycle at clear ptr=9 -> busy stays high a further 16 cycles from the release; requests issued during busy yield no vld and no write.
REQ-034 With DUALPORT_MEM_OUTREG_EN defined, back-to-back reads of addrs 1 and 2 -> vld_a high on consecutive cycles, first at request+2.
